// File: rtl/qspi_mem_arbiter_if.sv
// Bus bundle between the FazyRV requesters, the QSPI memory arbiter and the
// downstream QSPI XIP controller. The slave modport is the arbiter's view.
interface qspi_mem_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 24,
    parameter int DW   = 32
);
    logic [NREQ-1:0]        en_i;
    logic [NREQ-1:0]        req_cyc_i;
    logic [NREQ-1:0]        req_stb_i;
    logic [NREQ-1:0]        req_we_i;
    logic [NREQ*AW-1:0]     req_adr_i;
    logic [NREQ*DW-1:0]     req_dat_i;
    logic [NREQ*DW/8-1:0]   req_sel_i;
    logic [NREQ-1:0]        req_ack_o;
    logic [NREQ-1:0]        req_err_o;
    logic [DW-1:0]          req_dat_o;

    logic                   mem_cyc_o;
    logic                   mem_stb_o;
    logic                   mem_we_o;
    logic [AW-1:0]          mem_adr_o;
    logic [DW-1:0]          mem_dat_o;
    logic [DW/8-1:0]        mem_sel_o;
    logic                   mem_ack_i;
    logic [DW-1:0]          mem_dat_i;

    logic [NREQ-1:0]        grant_o;

    modport slave (
        input  en_i, req_cyc_i, req_stb_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        output req_ack_o, req_err_o, req_dat_o,
        output mem_cyc_o, mem_stb_o, mem_we_o, mem_adr_o, mem_dat_o, mem_sel_o,
        input  mem_ack_i, mem_dat_i,
        output grant_o
    );

    modport master (
        output en_i, req_cyc_i, req_stb_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        input  req_ack_o, req_err_o, req_dat_o,
        input  mem_cyc_o, mem_stb_o, mem_we_o, mem_adr_o, mem_dat_o, mem_sel_o,
        output mem_ack_i, mem_dat_i,
        input  grant_o
    );
endinterface

// File: rtl/qspi_mem_arbiter.sv
// Round-robin arbiter sharing one QSPI XIP Wishbone port between NREQ cores.
// One single transfer at a time: IDLE (decide) -> BUSY (forward) -> DONE (respond).
module qspi_mem_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 24,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    qspi_mem_arbiter_if.slave    bus
);
    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int SW = DW / 8;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NREQ-1:0]    pending;
    logic               any_pending;
    logic [IW-1:0]      sel_idx;
    logic               start;
    logic               finish_ack;
    logic               finish_err;

    logic [IW-1:0]      last_q;
    logic [IW-1:0]      idx_q;
    logic [NREQ-1:0]    grant_q;
    logic [NREQ-1:0]    ack_q;
    logic [NREQ-1:0]    err_q;
    logic [TW-1:0]      timer_q;
    logic               we_q;
    logic [AW-1:0]      adr_q;
    logic [DW-1:0]      dat_q;
    logic [SW-1:0]      sel_q;
    logic [DW-1:0]      rdat_q;

    assign pending = bus.req_cyc_i & bus.req_stb_i & bus.en_i;

    // Scan starts just after the last served requester, so it has lowest priority.
    always_comb begin
        any_pending = 1'b0;
        sel_idx     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!any_pending && pending[(int'(last_q) + i) % NREQ]) begin
                any_pending = 1'b1;
                sel_idx     = IW'((int'(last_q) + i) % NREQ);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        finish_ack = 1'b0;
        finish_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_pending) begin
                    start   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A late ack on the final cycle still counts as success.
                if (bus.mem_ack_i) begin
                    finish_ack = 1'b1;
                    state_d    = DONE;
                end else if (timer_q == TIMER_LAST) begin
                    finish_err = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_cyc_o = 1'b0;
        bus.mem_stb_o = 1'b0;
        bus.req_ack_o = '0;
        bus.req_err_o = '0;
        if (state_q == BUSY) begin
            bus.mem_cyc_o = 1'b1;
            bus.mem_stb_o = 1'b1;
        end
        if (state_q == DONE) begin
            bus.req_ack_o = ack_q;
            bus.req_err_o = err_q;
        end
    end

    assign bus.mem_we_o  = we_q;
    assign bus.mem_adr_o = adr_q;
    assign bus.mem_dat_o = dat_q;
    assign bus.mem_sel_o = sel_q;
    assign bus.req_dat_o = rdat_q;
    assign bus.grant_o   = grant_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q  <= IW'(NREQ - 1);
            idx_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            timer_q <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdat_q  <= '0;
        end else begin
            // The request is captured once; later req_* changes cannot disturb it.
            if (start) begin
                idx_q   <= sel_idx;
                grant_q <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
                we_q    <= bus.req_we_i[sel_idx];
                adr_q   <= bus.req_adr_i[sel_idx*AW +: AW];
                dat_q   <= bus.req_dat_i[sel_idx*DW +: DW];
                sel_q   <= bus.req_sel_i[sel_idx*SW +: SW];
                timer_q <= '0;
            end
            if (state_q == BUSY) begin
                timer_q <= timer_q + 1'b1;
            end
            if (finish_ack) begin
                ack_q  <= grant_q;
                rdat_q <= bus.mem_dat_i;
                last_q <= idx_q;
            end
            if (finish_err) begin
                err_q  <= grant_q;
                last_q <= idx_q;
            end
            if (state_q == DONE) begin
                ack_q   <= '0;
                err_q   <= '0;
                grant_q <= '0;
            end
        end
    end
endmodule
